// File: rtl/saph_fpu_arb.sv
// saph_fpu_arb: shares one fixed-latency FPU between GPUS request ports and routes each result back by tag.
// Arbitration is fixed priority (port 0 highest) unless SAPH_FPU_ARB_RR_EN is defined, which selects round-robin.
module saph_fpu_arb #(
    parameter int GPUS    = 4,
    parameter int LATENCY = 3,
    parameter int W       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [GPUS-1:0]              gpu_d_trig,
    output logic [GPUS-1:0]              gpu_d_ready,
    input  logic [GPUS*W-1:0]            gpu_d_lhs,
    input  logic [GPUS*W-1:0]            gpu_d_rhs,
    input  logic [GPUS*2-1:0]            gpu_d_mode,
    output logic [GPUS-1:0]              gpu_q_trig,
    output logic [W-1:0]                 gpu_q_res,
    output logic                         fpu_d_trig,
    input  logic                         fpu_d_ready,
    output logic [W-1:0]                 fpu_d_lhs,
    output logic [W-1:0]                 fpu_d_rhs,
    output logic [1:0]                   fpu_d_mode,
    input  logic                         fpu_q_trig,
    input  logic [W-1:0]                 fpu_q_res,
    output logic [$clog2(LATENCY+1)-1:0] inflight,
    output logic                         err
);

    localparam int IDX_W = (GPUS > 1) ? $clog2(GPUS) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    generate
        if (GPUS < 1 || LATENCY < 1) begin : g_param_check
            $error("saph_fpu_arb: GPUS and LATENCY must both be >= 1");
        end
    endgenerate

    logic [GPUS-1:0]  req;
    logic [GPUS-1:0]  grant;
    logic             grant_any;
    logic [IDX_W-1:0] grant_idx;

    logic [W-1:0]     lhs_slice  [GPUS];
    logic [W-1:0]     rhs_slice  [GPUS];
    logic [1:0]       mode_slice [GPUS];

    logic             tag_valid_reg [LATENCY];
    logic [IDX_W-1:0] tag_idx_reg   [LATENCY];
    logic             tag_out_valid;
    logic [IDX_W-1:0] tag_out_idx;

    logic [CNT_W-1:0] inflight_reg;
    logic             err_reg;

    // Nothing can be granted while in reset or while the FPU is not accepting.
    assign req = (rst || !fpu_d_ready) ? '0 : gpu_d_trig;

`ifdef SAPH_FPU_ARB_RR_EN
    logic [IDX_W-1:0] ptr_reg;

    // Winner is the requester with the smallest wrapped distance from the pointer.
    always_comb begin
        int dist;
        int best_dist;
        grant_any = 1'b0;
        grant_idx = '0;
        best_dist = GPUS;
        dist      = 0;
        for (int i = 0; i < GPUS; i++) begin
            dist = (i >= int'(ptr_reg)) ? (i - int'(ptr_reg)) : (i + GPUS - int'(ptr_reg));
            if (req[i] && (dist < best_dist)) begin
                best_dist = dist;
                grant_any = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (grant_any) begin
            ptr_reg <= (grant_idx == IDX_W'(GPUS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = GPUS - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < GPUS; gi++) begin : g_port
            assign grant[gi]      = grant_any && (grant_idx == IDX_W'(gi));
            assign lhs_slice[gi]  = gpu_d_lhs[gi*W +: W];
            assign rhs_slice[gi]  = gpu_d_rhs[gi*W +: W];
            assign mode_slice[gi] = gpu_d_mode[gi*2 +: 2];
            assign gpu_q_trig[gi] = !rst && fpu_q_trig && tag_out_valid
                                    && (tag_out_idx == IDX_W'(gi));
        end
    endgenerate

    assign gpu_d_ready = grant;
    assign fpu_d_trig  = grant_any;

    // AND-OR mux keeps the FPU operands at zero whenever nothing is granted.
    always_comb begin
        fpu_d_lhs  = '0;
        fpu_d_rhs  = '0;
        fpu_d_mode = '0;
        for (int i = 0; i < GPUS; i++) begin
            if (grant[i]) begin
                fpu_d_lhs  = fpu_d_lhs | lhs_slice[i];
                fpu_d_rhs  = fpu_d_rhs | rhs_slice[i];
                fpu_d_mode = fpu_d_mode | mode_slice[i];
            end
        end
    end

    assign tag_out_valid = tag_valid_reg[LATENCY-1];
    assign tag_out_idx   = tag_idx_reg[LATENCY-1];

    // A tag is pushed every cycle; the one at the tail lines up with this cycle's FPU result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_valid_reg[k] <= 1'b0;
                tag_idx_reg[k]   <= '0;
            end
            inflight_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            tag_valid_reg[0] <= grant_any;
            tag_idx_reg[0]   <= grant_idx;
            for (int k = 1; k < LATENCY; k++) begin
                tag_valid_reg[k] <= tag_valid_reg[k-1];
                tag_idx_reg[k]   <= tag_idx_reg[k-1];
            end
            inflight_reg <= inflight_reg + CNT_W'(grant_any) - CNT_W'(tag_out_valid);
            if (fpu_q_trig != tag_out_valid) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign gpu_q_res = fpu_q_res;
    assign inflight  = inflight_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_saph_fpu_arb.sv
// Scoreboard bench for saph_fpu_arb: a queue-based reference model predicts grants, results,
// inflight and err per cycle; an independent monitor compares on the falling edge.
`timescale 1ns/1ps
module tb_saph_fpu_arb;
    localparam int G  = 4;
    localparam int L  = 3;
    localparam int W  = 32;
    localparam int CW = $clog2(L + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [G-1:0]    gpu_d_trig;
    logic [G-1:0]    gpu_d_ready;
    logic [G*W-1:0]  gpu_d_lhs;
    logic [G*W-1:0]  gpu_d_rhs;
    logic [G*2-1:0]  gpu_d_mode;
    logic [G-1:0]    gpu_q_trig;
    logic [W-1:0]    gpu_q_res;
    logic            fpu_d_trig;
    logic            fpu_d_ready;
    logic [W-1:0]    fpu_d_lhs;
    logic [W-1:0]    fpu_d_rhs;
    logic [1:0]      fpu_d_mode;
    logic            fpu_q_trig;
    logic [W-1:0]    fpu_q_res;
    logic [CW-1:0]   inflight;
    logic            err;

    always #5 clk = ~clk;

    saph_fpu_arb #(.GPUS(G), .LATENCY(L), .W(W)) dut (
        .clk(clk), .rst(rst),
        .gpu_d_trig(gpu_d_trig), .gpu_d_ready(gpu_d_ready),
        .gpu_d_lhs(gpu_d_lhs), .gpu_d_rhs(gpu_d_rhs), .gpu_d_mode(gpu_d_mode),
        .gpu_q_trig(gpu_q_trig), .gpu_q_res(gpu_q_res),
        .fpu_d_trig(fpu_d_trig), .fpu_d_ready(fpu_d_ready),
        .fpu_d_lhs(fpu_d_lhs), .fpu_d_rhs(fpu_d_rhs), .fpu_d_mode(fpu_d_mode),
        .fpu_q_trig(fpu_q_trig), .fpu_q_res(fpu_q_res),
        .inflight(inflight), .err(err)
    );

    typedef struct {
        logic [G-1:0] grant;
        logic [W-1:0] lhs;
        logic [W-1:0] rhs;
        logic [1:0]   mode;
        int           inf;
        logic         err;
        bit           dgv;
        logic [G-1:0] dg;
        bit           dqv;
        logic [G-1:0] dq;
        bit           div;
        int           dinf;
        bit           drv;
        logic [W-1:0] dres;
        bit           dev;
        logic         derr;
    } exp_t;

    typedef struct {
        int           due;
        int           idx;
        logic [W-1:0] val;
    } res_t;

    exp_t exp_q[$];
    res_t res_q[$];
    res_t fpu_q[$];
    int   hist[$];
    bit   err_m;
    int   ptr_m;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic         s_rst, s_ready, s_pulse;
    logic [G-1:0] s_trig;
    logic [W-1:0] s_lhs [G];
    logic [W-1:0] s_rhs [G];
    logic [1:0]   s_mode [G];

    bit           d_gv, d_qv, d_iv, d_rv, d_ev;
    logic [G-1:0] d_g, d_q;
    int           d_inf;
    logic [W-1:0] d_res;
    logic         d_err;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] fpu_op(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] m);
        return a + b + W'(m);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp_v);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < G; i++) begin
            s_lhs[i]  = W'($urandom);
            s_rhs[i]  = W'($urandom);
            s_mode[i] = 2'($urandom);
        end
    endtask

    // One clock of stimulus plus the reference model's prediction for that cycle.
    task automatic step();
        exp_t e;
        res_t r;
        int   win;
        int   cnt;
        bit   tag_v;
        @(posedge clk);
        #1;
        rst         = s_rst;
        fpu_d_ready = s_ready;
        gpu_d_trig  = s_trig;
        for (int i = 0; i < G; i++) begin
            gpu_d_lhs[i*W +: W]  = s_lhs[i];
            gpu_d_rhs[i*W +: W]  = s_rhs[i];
            gpu_d_mode[i*2 +: 2] = s_mode[i];
        end
        fpu_q_trig = 1'b0;
        fpu_q_res  = W'($urandom);
        if (fpu_q.size() > 0 && fpu_q[0].due == cyc) begin
            r          = fpu_q.pop_front();
            fpu_q_trig = 1'b1;
            fpu_q_res  = r.val;
        end
        if (s_pulse) fpu_q_trig = 1'b1;

        win = -1;
        if (!s_rst && s_ready) begin
            for (int k = 0; k < G; k++) begin
`ifdef SAPH_FPU_ARB_RR_EN
                if (win < 0 && s_trig[(ptr_m + k) % G]) win = (ptr_m + k) % G;
`else
                if (win < 0 && s_trig[k]) win = k;
`endif
            end
        end
        cnt   = 0;
        tag_v = 0;
        foreach (hist[j]) begin
            if (hist[j] >= cyc - L) cnt++;
            if (hist[j] == cyc - L) tag_v = 1;
        end
        e.grant = (win >= 0) ? (G'(1) << win) : '0;
        e.lhs   = (win >= 0) ? s_lhs[win]  : '0;
        e.rhs   = (win >= 0) ? s_rhs[win]  : '0;
        e.mode  = (win >= 0) ? s_mode[win] : '0;
        e.inf   = cnt;
        e.err   = err_m;
        e.dgv = d_gv; e.dg = d_g; e.dqv = d_qv; e.dq = d_q;
        e.div = d_iv; e.dinf = d_inf; e.drv = d_rv; e.dres = d_res;
        e.dev = d_ev; e.derr = d_err;
        exp_q.push_back(e);

        if (s_rst) begin
            hist.delete();
            res_q.delete();
            fpu_q.delete();
            err_m = 0;
            ptr_m = 0;
        end else begin
            if (fpu_q_trig != tag_v) err_m = 1;
            if (win >= 0) begin
                hist.push_back(cyc);
                res_q.push_back('{due: cyc + L, idx: win, val: fpu_op(s_lhs[win], s_rhs[win], s_mode[win])});
                ptr_m = (win + 1) % G;
            end
            while (hist.size() > 0 && hist[0] < cyc + 1 - L) void'(hist.pop_front());
        end
        d_gv = 0; d_qv = 0; d_iv = 0; d_rv = 0; d_ev = 0;
    endtask

    task automatic idle(input int n);
        s_rst = 0; s_ready = 1; s_trig = '0; s_pulse = 0;
        repeat (n) begin
            rand_ops();
            step();
        end
    endtask

    // Bench-side FPU: answers whatever the arbiter actually issues, L cycles later.
    always @(negedge clk) begin
        if (fpu_d_trig === 1'b1)
            fpu_q.push_back('{due: cyc + L, idx: 0, val: fpu_op(fpu_d_lhs, fpu_d_rhs, fpu_d_mode)});
    end

    exp_t me;
    res_t mr;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("grant", 64'(gpu_d_ready), 64'(me.grant));
            chk("fpu_d_trig", 64'(fpu_d_trig), 64'(|me.grant));
            chk("fpu_d_lhs", 64'(fpu_d_lhs), 64'(me.lhs));
            chk("fpu_d_rhs", 64'(fpu_d_rhs), 64'(me.rhs));
            chk("fpu_d_mode", 64'(fpu_d_mode), 64'(me.mode));
            chk("inflight", 64'(inflight), 64'(me.inf));
            chk("err", 64'(err), 64'(me.err));
            if (me.dgv) chk("dir_grant", 64'(gpu_d_ready), 64'(me.dg));
            if (me.dqv) chk("dir_qtrig", 64'(gpu_q_trig), 64'(me.dq));
            if (me.div) chk("dir_inflight", 64'(inflight), 64'(me.dinf));
            if (me.drv) chk("dir_res", 64'(gpu_q_res), 64'(me.dres));
            if (me.dev) chk("dir_err", 64'(err), 64'(me.derr));
            if (gpu_q_trig !== '0) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", 64'(gpu_q_trig), 64'(0));
                end else begin
                    mr = res_q.pop_front();
                    chk("res_port", 64'(gpu_q_trig), 64'(G'(1) << mr.idx));
                    chk("res_val", 64'(gpu_q_res), 64'(mr.val));
                    chk("res_time", 64'(cyc), 64'(mr.due));
                    $display("[TB] cyc=%0d result port=%0d val=%h", cyc, mr.idx, gpu_q_res);
                end
            end else if (res_q.size() > 0 && res_q[0].due <= cyc) begin
                mr = res_q.pop_front();
                chk("missing_result", 64'(gpu_q_trig), 64'(G'(1) << mr.idx));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fpu_d_ready = 1'b0; gpu_d_trig = '0;
        gpu_d_lhs = '0; gpu_d_rhs = '0; gpu_d_mode = '0;
        fpu_q_trig = 1'b0; fpu_q_res = '0;
        err_m = 0; ptr_m = 0;
        d_gv = 0; d_qv = 0; d_iv = 0; d_rv = 0; d_ev = 0;
        d_g = '0; d_q = '0; d_inf = 0; d_res = '0; d_err = 1'b0;
        s_pulse = 0;
        rand_ops();

        // Reset with every port requesting: no grants, counters cleared.
        s_rst = 1; s_ready = 1; s_trig = '1;
        repeat (2) begin
            d_gv = 1; d_g = '0; d_iv = 1; d_inf = 0; d_ev = 1; d_err = 0;
            step();
        end

        // All four ports request continuously.
        s_rst = 0; s_trig = '1;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            d_gv = 1;
`ifdef SAPH_FPU_ARB_RR_EN
            d_g = G'(1) << (k % G);
`else
            d_g = G'(1);
`endif
            if (k >= L) begin
                d_qv = 1;
`ifdef SAPH_FPU_ARB_RR_EN
                d_q = G'(1) << ((k - L) % G);
`else
                d_q = G'(1);
`endif
            end
            step();
        end
        idle(L + 1);

        // Reset with two operations in flight: they are discarded.
        s_trig = 4'b0001;
        repeat (2) begin rand_ops(); step(); end
        s_trig = '0; s_rst = 1;
        d_iv = 1; d_inf = 2; d_qv = 1; d_q = '0;
        step();
        s_rst = 0;
        d_iv = 1; d_inf = 0; d_ev = 1; d_err = 0; d_qv = 1; d_q = '0;
        step();
        d_iv = 1; d_inf = 0; d_qv = 1; d_q = '0;
        step();
        idle(2);

        // Ports 1 and 3 contend.
        s_trig = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            rand_ops();
            d_gv = 1;
`ifdef SAPH_FPU_ARB_RR_EN
            d_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
`else
            d_g = 4'b0010;
`endif
            step();
        end
        idle(L + 1);

        // FPU not ready: no grants and the pointer holds.
        s_rst = 1; s_trig = '0; step();
        s_rst = 0; s_ready = 0; s_trig = 4'b0101;
        repeat (3) begin rand_ops(); d_gv = 1; d_g = '0; step(); end
        s_ready = 1;
        d_gv = 1; d_g = 4'b0001; step();
`ifdef SAPH_FPU_ARB_RR_EN
        d_gv = 1; d_g = 4'b0100; step();
`else
        d_gv = 1; d_g = 4'b0001; step();
`endif
        idle(L + 1);

        // Single operation on port 2, result routed back after L cycles.
        rand_ops();
        s_trig = 4'b0100; s_lhs[2] = 32'h3F80_0000; s_rhs[2] = 32'h0080_0000; s_mode[2] = 2'd0;
        d_gv = 1; d_g = 4'b0100; d_iv = 1; d_inf = 0;
        step();
        s_trig = '0;
        d_iv = 1; d_inf = 1; step();
        d_iv = 1; d_inf = 1; step();
        d_iv = 1; d_inf = 1; d_qv = 1; d_q = 4'b0100; d_rv = 1; d_res = 32'h4000_0000; step();
        d_iv = 1; d_inf = 0; step();

        // Stray FPU result right after reset raises a sticky error.
        s_rst = 1; step();
        s_rst = 0; s_pulse = 1;
        d_ev = 1; d_err = 0; d_qv = 1; d_q = '0;
        step();
        s_pulse = 0;
        repeat (3) begin d_ev = 1; d_err = 1; step(); end
        s_rst = 1; d_ev = 1; d_err = 1; step();
        s_rst = 0; d_ev = 1; d_err = 0; step();

        // Randomized traffic with occasional resets and FPU back-pressure.
        for (int k = 0; k < 400; k++) begin
            rand_ops();
            s_rst   = ($urandom_range(0, 63) == 0);
            s_ready = ($urandom_range(0, 3) != 0);
            s_trig  = G'($urandom);
            step();
        end
        idle(L + 3);
        chk("drain", 64'(res_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
